// File: rtl/sound_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_pkg : codec I2C address, codec register map and arbiter FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package sound_pkg;

  localparam logic [7:0] CODEC_I2C_ADDR = 8'h34;

  // Codec register addresses, already shifted into the 7-bit-address/9-bit-data word
  localparam logic [7:0] L_LINE_CTRL  = 8'h00;
  localparam logic [7:0] R_LINE_CTRL  = 8'h02;
  localparam logic [7:0] L_HEAD_CTRL  = 8'h04;
  localparam logic [7:0] R_HEAD_CTRL  = 8'h06;
  localparam logic [7:0] ANALOG_PATH  = 8'h08;
  localparam logic [7:0] DIGITAL_PATH = 8'h0A;
  localparam logic [7:0] PW_DOWN_CTRL = 8'h0C;
  localparam logic [7:0] AUDIO_FORMAT = 8'h0E;
  localparam logic [7:0] SAMPLE_CTRL  = 8'h10;
  localparam logic [7:0] ACTIVE       = 8'h12;
  localparam logic [7:0] CODEC_RESET  = 8'h1E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic logic [15:0] codec_word(input logic [7:0] reg_addr,
                                             input logic [7:0] value);
    return {reg_addr, value};
  endfunction

endpackage
`default_nettype wire

// File: rtl/codec_i2c_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// codec_i2c_arbiter_if : requester and I2C-generator signals of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface codec_i2c_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][15:0] req_data;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  busy;
  logic [GW-1:0]         grant;
  logic                  go;
  logic [23:0]           i2c_data;
  logic                  i2c_end;
  logic                  i2c_ack;

  modport slave (
    input  req, req_data, i2c_end, i2c_ack,
    output done, err, busy, grant, go, i2c_data
  );

  modport master (
    output req, req_data, i2c_end, i2c_ack,
    input  done, err, busy, grant, go, i2c_data
  );

endinterface
`default_nettype wire

// File: rtl/codec_i2c_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching from last grant + 1
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  wire [NREQ-1:0] req,
  input  wire [GW-1:0]   last,
  output logic           valid,
  output logic [GW-1:0]  pick
);

  localparam logic [GW:0] N_W = (GW + 1)'(NREQ);

  logic [GW:0] cand;

  // One extra bit holds last+offset before the single modulo-NREQ fold
  always_comb begin
    valid = 1'b0;
    pick  = last;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, last} + (GW + 1)'(i + 1);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!valid && req[cand[GW-1:0]]) begin
        valid = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/codec_i2c_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// codec_i2c_arbiter : round-robin sharing of the codec I2C generator with retry/timeout
// Rev 1.0
// ---------------------------------------------------------------------------
module codec_i2c_arbiter
  import sound_pkg::*;
#(
  parameter int         NREQ      = 2,
  parameter logic [7:0] DEV_ADDR  = CODEC_I2C_ADDR,
  parameter int         MAX_RETRY = 3,
  parameter int         TIMEOUT   = 64
) (
  input wire                 clk,
  input wire                 nrst,
  input wire                 en,
  codec_i2c_arbiter_if.slave bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GRANT_RST = GW'(NREQ - 1);

  arb_state_t      state;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  logic            go_q;
  logic            err_q;
  logic            result;
  logic            restart;
  logic [NREQ-1:0] done_q;
  logic [23:0]     data_q;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_next;
  logic [RW-1:0]   rcnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr (
    .req   (bus.req),
    .last  (grant_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  assign tcnt_next = (tcnt == TMAX) ? tcnt : tcnt + 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      grant_q <= GRANT_RST;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
      result  <= 1'b0;
      restart <= 1'b0;
      done_q  <= '0;
      data_q  <= '0;
      tcnt    <= '0;
      rcnt    <= '0;
    end else begin
      // done/err live for one clk regardless of the tick
      done_q <= '0;
      err_q  <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (pick_valid) begin
              grant_q <= pick;
              data_q  <= {DEV_ADDR, bus.req_data[pick]};
              go_q    <= 1'b1;
              tcnt    <= '0;
              rcnt    <= '0;
              restart <= 1'b0;
              result  <= 1'b0;
              state   <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            tcnt <= tcnt_next;
            if (bus.i2c_end) begin
              go_q  <= 1'b0;
              state <= ST_GAP;
              if (bus.i2c_ack && (rcnt < RMAX)) begin
                rcnt    <= rcnt + 1'b1;
                restart <= 1'b1;
                result  <= 1'b0;
              end else begin
                restart <= 1'b0;
                result  <= bus.i2c_ack;
              end
            end else if (tcnt_next == TMAX) begin
              go_q    <= 1'b0;
              restart <= 1'b0;
              result  <= 1'b1;
              state   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (restart) begin
              go_q    <= 1'b1;
              tcnt    <= '0;
              restart <= 1'b0;
              state   <= ST_BUSY;
            end else begin
              done_q[grant_q] <= 1'b1;
              err_q           <= result;
              state           <= ST_IDLE;
            end
          end
          default: begin
            go_q  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.grant    = grant_q;
  assign bus.go       = go_q;
  assign bus.i2c_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_i2c_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_codec_i2c_arbiter : directed bench with an I2C generator model on a fast tick
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_codec_i2c_arbiter;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // generator model configuration (written by tasks only)
  int gen_lat = 0;
  int gen_nacks = 0;
  int gen_base = 0;

  // monitor state (written by the monitor process only)
  int attempts = 0;
  int gen_cnt = 0;
  int div = 0;
  int tick_no = 0;
  int go_pulses = 0;
  int go_len = 0;
  int low_len = 0;
  int last_len = 0;
  int last_low = 0;
  int go_rise_tick = 0;
  int done_tick = 0;
  int done_wide = 0;
  int err_stray = 0;
  int log_n = 0;
  int grant_log [0:63];
  logic go_prev = 1'b0;
  logic done_prev = 1'b0;

  codec_i2c_arbiter_if #(.NREQ(2)) bus ();

  codec_i2c_arbiter #(
    .NREQ      (2),
    .DEV_ADDR  (8'h34),
    .MAX_RETRY (3),
    .TIMEOUT   (64)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Tick generator, I2C generator model and output monitor, all on the falling edge
  initial begin
    bus.i2c_end = 1'b0;
    bus.i2c_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (en) begin
        tick_no++;
        if (bus.go && !go_prev) begin
          go_pulses++;
          last_low = low_len;
          go_len = 0;
          go_rise_tick = tick_no;
        end
        if (!bus.go && go_prev) begin
          last_len = go_len;
          low_len = 0;
        end
        if (bus.go) go_len++;
        else low_len++;
        go_prev = bus.go;
        if (bus.go && !bus.i2c_end) begin
          gen_cnt++;
          if (gen_lat != 0 && gen_cnt == gen_lat) begin
            bus.i2c_end = 1'b1;
            bus.i2c_ack = ((attempts - gen_base) < gen_nacks);
            attempts++;
          end
        end
      end
      if (!bus.go) begin
        bus.i2c_end = 1'b0;
        bus.i2c_ack = 1'b0;
        gen_cnt = 0;
      end
      if (bus.done != 2'b00) begin
        if (done_prev) done_wide++;
        done_tick = tick_no;
        if (log_n < 64) begin
          grant_log[log_n] = bus.done[1] ? 1 : 0;
          log_n++;
        end
      end
      if (bus.done == 2'b00 && bus.err) err_stray++;
      done_prev = (bus.done != 2'b00);
      div = (div + 1) % 4;
      en = (div == 0);
    end
  end

  task automatic set_gen(input int lat, input int nacks);
    gen_lat = lat;
    gen_nacks = nacks;
    gen_base = attempts;
  endtask

  task automatic wait_go(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.go) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_go: go still 0 after %0d clk, required 1", budget);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.done != 2'b00) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_done: done still 0 after %0d clk, required a pulse", budget);
    end
  endtask

  task automatic test_reset();
    bus.req = 2'b00;
    bus.req_data = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    vectors++; if (bus.go !== 1'b0) begin miscompares++; $display("FAIL rst_go: got %b expected 0", bus.go); end
    vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL rst_done: got %b expected 00", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.grant !== 1'b1) begin miscompares++; $display("FAIL rst_grant: got %b expected 1", bus.grant); end
    vectors++; if (bus.i2c_data !== 24'h000000) begin miscompares++; $display("FAIL rst_data: got %h expected 000000", bus.i2c_data); end
  endtask

  task automatic test_single_write();
    bit ok;
    set_gen(27, 0);
    bus.req_data[0] = 16'h0C00;
    bus.req[0] = 1'b1;
    wait_go(40, ok);
    vectors++; if (bus.i2c_data !== 24'h340C00) begin miscompares++; $display("FAIL single_data: got %h expected 340C00", bus.i2c_data); end
    vectors++; if (bus.grant !== 1'b0) begin miscompares++; $display("FAIL single_grant: got %b expected 0", bus.grant); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    bus.req_data[0] = 16'hFFFF;
    wait_done(2000, ok);
    bus.req[0] = 1'b0;
    vectors++; if (bus.done !== 2'b01) begin miscompares++; $display("FAIL single_done: got %b expected 01", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b expected 0", bus.err); end
    vectors++; if (bus.i2c_data !== 24'h340C00) begin miscompares++; $display("FAIL single_relatch: got %h expected 340C00", bus.i2c_data); end
    @(negedge clk); #1;
    vectors++; if (last_len !== 27) begin miscompares++; $display("FAIL single_go_ticks: got %0d expected 27", last_len); end
    vectors++; if ((done_tick - go_rise_tick) !== 28) begin miscompares++; $display("FAIL single_done_tick: got %0d expected 28", done_tick - go_rise_tick); end
    @(posedge clk); #1;
    vectors++; if (bus.done !== 2'b00 || bus.err !== 1'b0) begin miscompares++; $display("FAIL single_done_width: got done=%b err=%b expected 00/0", bus.done, bus.err); end
  endtask

  task automatic test_retry();
    bit ok;
    int p0;
    set_gen(5, 2);
    p0 = go_pulses;
    bus.req_data[1] = 16'h0E42;
    bus.req[1] = 1'b1;
    wait_done(4000, ok);
    bus.req[1] = 1'b0;
    vectors++; if (bus.done !== 2'b10) begin miscompares++; $display("FAIL retry_done: got %b expected 10", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL retry_err: got %b expected 0", bus.err); end
    vectors++; if (bus.grant !== 1'b1) begin miscompares++; $display("FAIL retry_grant: got %b expected 1", bus.grant); end
    vectors++; if (bus.i2c_data !== 24'h340E42) begin miscompares++; $display("FAIL retry_data: got %h expected 340E42", bus.i2c_data); end
    @(negedge clk); #1;
    vectors++; if ((go_pulses - p0) !== 3) begin miscompares++; $display("FAIL retry_pulses: got %0d expected 3", go_pulses - p0); end
    vectors++; if (last_low !== 1) begin miscompares++; $display("FAIL retry_gap: got %0d expected 1", last_low); end
  endtask

  task automatic test_round_robin();
    int rem [2];
    int n;
    int base;
    set_gen(4, 0);
    rem[0] = 5;
    rem[1] = 5;
    n = 0;
    base = log_n;
    bus.req_data[0] = 16'h0417;
    bus.req_data[1] = 16'h0679;
    bus.req = 2'b11;
    for (int c = 0; c < 6000 && n < 10; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (bus.done[i]) begin
          n++;
          rem[i]--;
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && rem[i] > 0) begin
          bus.req[i] = 1'b1;
        end
      end
    end
    bus.req = 2'b00;
    @(negedge clk); #1;
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL rr_count: got %0d writes expected 10", n); end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ((base + k >= log_n) || (grant_log[base + k] !== (k % 2))) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", k, (base + k < log_n) ? grant_log[base + k] : -1, k % 2);
      end
    end
  endtask

  task automatic test_nack_all();
    bit ok;
    int p0;
    set_gen(3, 100);
    p0 = go_pulses;
    bus.req_data[0] = 16'h1201;
    bus.req[0] = 1'b1;
    wait_done(4000, ok);
    bus.req[0] = 1'b0;
    vectors++; if (bus.done !== 2'b01) begin miscompares++; $display("FAIL nack_done: got %b expected 01", bus.done); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL nack_err: got %b expected 1", bus.err); end
    @(negedge clk); #1;
    vectors++; if ((go_pulses - p0) !== 4) begin miscompares++; $display("FAIL nack_pulses: got %0d expected 4", go_pulses - p0); end
  endtask

  task automatic test_timeout();
    bit ok;
    set_gen(0, 0);
    bus.req_data[1] = 16'h0479;
    bus.req[1] = 1'b1;
    wait_done(4000, ok);
    bus.req[1] = 1'b0;
    vectors++; if (bus.done !== 2'b10) begin miscompares++; $display("FAIL tmo_done: got %b expected 10", bus.done); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b expected 1", bus.err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy: got %b expected 0", bus.busy); end
    @(negedge clk); #1;
    vectors++; if (last_len !== 64) begin miscompares++; $display("FAIL tmo_go_ticks: got %0d expected 64", last_len); end
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    set_gen(0, 0);
    bus.req_data[0] = 16'h0A12;
    bus.req[0] = 1'b1;
    wait_go(40, ok);
    repeat (20) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    vectors++; if (bus.go !== 1'b0) begin miscompares++; $display("FAIL rmid_go: got %b expected 0", bus.go); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL rmid_done: got %b expected 00", bus.done); end
    vectors++; if (bus.grant !== 1'b1) begin miscompares++; $display("FAIL rmid_grant_rst: got %b expected 1", bus.grant); end
    repeat (2) @(negedge clk);
    set_gen(3, 0);
    bus.req_data[1] = 16'h0C11;
    bus.req[1] = 1'b1;
    nrst = 1'b1;
    wait_go(40, ok);
    vectors++; if (bus.grant !== 1'b0) begin miscompares++; $display("FAIL rmid_regrant: got %b expected 0", bus.grant); end
    vectors++; if (bus.i2c_data !== 24'h340A12) begin miscompares++; $display("FAIL rmid_data: got %h expected 340A12", bus.i2c_data); end
    wait_done(2000, ok);
    bus.req = 2'b00;
    vectors++; if (bus.done !== 2'b01 || bus.err !== 1'b0) begin miscompares++; $display("FAIL rmid_result: got done=%b err=%b expected 01/0", bus.done, bus.err); end
  endtask

  task automatic test_pulse_hygiene();
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (done_wide !== 0) begin miscompares++; $display("FAIL done_width: got %0d wide pulses expected 0", done_wide); end
    vectors++; if (err_stray !== 0) begin miscompares++; $display("FAIL err_without_done: got %0d expected 0", err_stray); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_retry();
    test_round_robin();
    test_nack_all();
    test_timeout();
    test_reset_mid_transfer();
    test_pulse_hygiene();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/codec_i2c_arbiter.md
# codec_i2c_arbiter

Shares the single I2C sequence generator (`I2C`) between NREQ requesters: the boot-time codec configuration sequencer, runtime volume/mute control from game logic, and similar clients. Grants one 16-bit codec register write at a time, round-robin. Prefixes the codec device address, drives the generator's GO/END handshake, retries on NACK and aborts on timeout. Runs on the system clock; advances only on the I2C tick (`en`) produced by the sound block's clock divider.

## Interface
- NREQ, 2: number of requesters (2..4)
- DEV_ADDR, 8'h34: codec I2C address, forms `i2c_data[23:16]`
- MAX_RETRY, 3: extra attempts after a NACK
- TIMEOUT, 64: en ticks allowed between GO rising and END
- clk  in  1  system clock (50 MHz)
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  one-clk I2C tick strobe (clk/1024)
- req  in  NREQ  per-requester write request, level, held until done
- req_data  in  NREQ×16  per-requester {reg_addr[7:0], value[7:0]}
- done  out  NREQ  one-clk pulse to the granted requester when its write finishes
- err  out  1  valid with done: 1 = retries exhausted or timeout
- busy  out  1  transfer in progress (state ≠ IDLE)
- grant  out  $clog2(NREQ)  index of current/last granted requester
- go  out  1  GO to I2C generator
- i2c_data  out  24  {DEV_ADDR, latched req_data}
- i2c_end  in  1  END from I2C generator
- i2c_ack  in  1  ACK from I2C generator, 1 = NACK (transfer failed)

## Operation
- FSM states: IDLE, BUSY, GAP. All transitions and register updates happen only in clk cycles where en=1, except done/err clearing.
- IDLE: if any req bit is set, choose round-robin starting after `grant`, latch that requester's data into i2c_data, set go=1, clear retry and timeout counters, → BUSY.
- BUSY: increment timeout counter each tick.
  - If i2c_end: go=0. A NACK with retry<MAX_RETRY increments retry and sets a pending restart. Otherwise the result is ok (ack=0) or err (NACK). → GAP.
  - Else if counter reaches TIMEOUT: go=0, result=err, → GAP.
- GAP: go stays low for this tick.
  - On a pending restart: go=1, clear the timeout counter, → BUSY. Data is not re-latched.
  - Otherwise: done[grant]=1 and err=result for this single clk, → IDLE.
- Round-robin: `grant` resets to NREQ-1, so requester 0 wins first. When all requesters are pending, grants rotate.
- req_data changes after grant are ignored. A req dropped mid-transfer does not abort the write; done still pulses.
- A requester deasserts req on seeing done. If req is still high at the next IDLE tick, it counts as a new request.
- Requests that do not hold the grant are never lost; they wait.

## Timing
- Reset values: go=0, done=0, err=0, busy=0, grant=NREQ-1, i2c_data=0, state IDLE, counters 0.
- Reset mid-transfer drops go immediately (async). The codec sees an aborted frame, and the requester must re-request.
- go rises on the first en tick that sees req in IDLE, at most 1024 clk after req rises.
- Minimum go low time between transfers: one tick, in GAP.
- done is asserted one tick after the tick that sees i2c_end.
- done and err are asserted exactly one clk each. err=0 whenever done is 0.
- Attempts per request ≤ MAX_RETRY+1. Worst-case ticks per request = (MAX_RETRY+1)×(TIMEOUT+1)+1.
- Timeout counter width: $clog2(TIMEOUT+1). Retry counter width: $clog2(MAX_RETRY+1). Neither counter wraps; both saturate at their limit.

## Structure
- Shared package `sound_pkg`:
  - CODEC_I2C_ADDR (8'h34)
  - codec register address constants (PW_DOWN_CTRL 0x0C, AUDIO_FORMAT 0x0E, L_HEAD_CTRL 0x04, ACTIVE 0x12, …)
  - FSM state enum `arb_state_t`
- One sub-module: `rr_arbiter`, combinational NREQ-way round-robin pick from req and last grant. The FSM stays in the top module.
- The sound block instantiates this arbiter between its config sequencer (requester 0) and the volume controller (requester 1).

## Test plan
- req[0]=1, req_data=16'h0C00, generator returns end with ack=0 after 27 ticks → i2c_data=24'h340C00, go high 27 ticks, done[0] one clk one tick later, err=0.
- req[1], generator NACKs twice then ACKs → go asserted 3 times, each separated by one low tick, then done[1] with err=0.
- Generator always NACKs, MAX_RETRY=3 → exactly 4 go pulses, then done with err=1.
- req[0] and req[1] pending continuously with 5 writes each → grants alternate 0,1,0,1…, starting with 0, with no starvation.
- Generator never asserts end → go drops after 64 ticks, then done with err=1 and busy=0.
- Assert nrst low in BUSY → go, busy and done are 0 in the same cycle. After release, a held req restarts from IDLE with grant order reset.
